// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32I core.
// Generates IR/PC/RF write enables and the imem/dmem request handshakes,
// with a memory wait timeout that traps into a sticky error state.
// Optional macro CPU_PERF_CNT_EN adds the cycle and retired-instruction counters.
module cpu_seq_ctrl #(
  parameter logic [15:0] MEM_TIMEOUT = 16'd255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_reg_we,
  input  logic             dec_is_halt,
  output logic             ex_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int unsigned TO_W = 16;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic            req_pending_q, req_pending_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            bus_err_q, bus_err_d;
  logic            waiting;
  logic            expire;

  // State and handshake bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IF;
      req_pending_q <= 1'b0;
      to_cnt_q      <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_pending_q <= req_pending_d;
      to_cnt_q      <= to_cnt_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Next state, strobes and timeout bookkeeping.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    ex_en    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    waiting  = 1'b0;
    expire   = (MEM_TIMEOUT != 16'd0) && (to_cnt_q == (MEM_TIMEOUT - 16'd1));

    case (state_q)
      S_IF: begin
        // Gate with rst_n so no fetch request escapes while held in reset.
        imem_req = rst_n & (run | req_pending_q);
        if (imem_req) begin
          waiting = 1'b1;
          if (imem_ready) begin
            ir_we   = 1'b1;
            state_d = S_ID;
          end else if (expire) begin
            state_d = S_ERR;
          end
        end
      end
      S_ID: begin
        state_d = dec_is_halt ? S_HALT : S_EX;
      end
      S_EX: begin
        ex_en   = 1'b1;
        state_d = (dec_is_load | dec_is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
        waiting  = 1'b1;
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (expire) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        rf_we   = dec_reg_we & ~dec_is_store;
        state_d = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    // Pending holds an issued fetch even if run drops before imem_ready.
    req_pending_d = (state_q == S_IF) && imem_req && !imem_ready;
    to_cnt_d      = (waiting && (state_d == state_q)) ? (to_cnt_q + TO_W'(1)) : '0;
    bus_err_d     = bus_err_q | (state_d == S_ERR);
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign bus_err = bus_err_q;

`ifdef CPU_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  // Performance counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if ((state_q != S_HALT) && (state_q != S_ERR)) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (state_q == S_WB) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: each instruction is described by its kind
// and memory wait counts, and the expected per-cycle output trace is derived
// from those; one negedge process compares the DUT against it.
module tb_cpu_seq_ctrl;

  localparam int unsigned CNT_W = 32;
  localparam int          TO    = 8;
`ifdef CPU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             run = 1'b0;
  logic             imem_req, imem_ready = 1'b0, ir_we;
  logic             dec_is_load = 1'b0, dec_is_store = 1'b0, dec_reg_we = 1'b0, dec_is_halt = 1'b0;
  logic             ex_en, dmem_req, dmem_we, dmem_ack = 1'b0;
  logic             rf_we, pc_we, halted, bus_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.MEM_TIMEOUT(16'(TO)), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_reg_we(dec_reg_we), .dec_is_halt(dec_is_halt),
    .ex_en(ex_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .state(state), .halted(halted), .bus_err(bus_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, ir_we, ex_en, dmem_req, dmem_we, rf_we, pc_we, bus_err;
  } exp_t;

  exp_t        exp_v;
  bit          chk_en = 1'b0;
  int          n_vec = 0, n_bad = 0, tick_n = 0, nc;
  int unsigned m_cyc = 0, m_ret = 0;
  bit          m_err = 1'b0;
  string       tag = "reset";

  function automatic exp_t mk(input logic [2:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    e.bus_err = m_err;
    return e;
  endfunction

  // Per-cycle compare of every output against the expected trace.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t act;
      logic [CNT_W-1:0] ec, er;
      act = {state, imem_req, ir_we, ex_en, dmem_req, dmem_we, rf_we, pc_we, bus_err};
      ec = PERF ? CNT_W'(m_cyc) : '0;
      er = PERF ? CNT_W'(m_ret) : '0;
      n_vec++;
      if (act !== exp_v || halted !== (exp_v.st == 3'd5) || cycle_cnt !== ec || instret_cnt !== er) begin
        n_bad++;
        $display("FAIL %s t=%0t: got st=%0d str=%b halted=%b cyc=%0d ret=%0d, want st=%0d str=%b halted=%b cyc=%0d ret=%0d",
                 tag, $time, act.st, act[7:0], halted, cycle_cnt, instret_cnt,
                 exp_v.st, exp_v[7:0], (exp_v.st == 3'd5), ec, er);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // One clock of expected behaviour; counters advance on active, non-reset cycles.
  task automatic tick(input exp_t e);
    exp_v  = e;
    chk_en = 1'b1;
    @(posedge clk);
    if (rst_n && e.st != 3'd5 && e.st != 3'd6) m_cyc++;
    if (rst_n && e.st == 3'd4) m_ret++;
    tick_n++;
    #1;
  endtask

  task automatic do_reset();
    tag = "reset";
    rst_n = 1'b0;
    #1;
    chk("rst_async_state", 64'(state), 64'd0);
    chk("rst_async_dmem_req", 64'(dmem_req), 64'd0);
    m_cyc = 0; m_ret = 0; m_err = 1'b0;
    imem_ready = 1'b0; dmem_ack = 1'b0;
    tick(mk(3'd0));
    tick(mk(3'd0));
    rst_n = 1'b1;
  endtask

  task automatic err_hold();
    m_err = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run = 1'b1; imem_ready = 1'b1; dmem_ack = 1'b1;
      tick(mk(3'd6));
    end
    imem_ready = 1'b0; dmem_ack = 1'b0;
  endtask

  // Expected trace of one instruction from its kind and wait counts.
  task automatic instr(input string nm, input logic ld, input logic sto, input logic rwe, input logic hlt,
                       input int w_if, input int w_mem, input bit drop, input bit abort, output int ncyc);
    exp_t e;
    int t0;
    t0 = tick_n;
    tag = nm;
    dec_is_load = ld; dec_is_store = sto; dec_reg_we = rwe; dec_is_halt = hlt;
    dmem_ack = 1'b0;
    for (int i = 0; i < w_if && i < TO; i++) begin
      run = (drop && i > 0) ? 1'b0 : 1'b1;
      imem_ready = 1'b0;
      e = mk(3'd0); e.imem_req = 1'b1;
      tick(e);
    end
    if (w_if >= TO) begin
      err_hold();
      ncyc = tick_n - t0;
      return;
    end
    run = (drop && w_if > 0) ? 1'b0 : 1'b1;
    imem_ready = 1'b1;
    e = mk(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1;
    tick(e);
    imem_ready = 1'b0; run = 1'b1;
    tick(mk(3'd1));
    if (hlt) begin
      ncyc = tick_n - t0;
      return;
    end
    e = mk(3'd2); e.ex_en = 1'b1;
    tick(e);
    if (ld | sto) begin
      e = mk(3'd3); e.dmem_req = 1'b1; e.dmem_we = sto;
      for (int i = 0; i < w_mem && i < TO; i++) tick(e);
      if (abort) begin
        ncyc = tick_n - t0;
        return;
      end
      if (w_mem >= TO) begin
        err_hold();
        ncyc = tick_n - t0;
        return;
      end
      dmem_ack = 1'b1;
      tick(e);
      dmem_ack = 1'b0;
    end
    e = mk(3'd4); e.pc_we = 1'b1; e.rf_we = rwe & ~sto;
    tick(e);
    ncyc = tick_n - t0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    instr("alu", 0, 0, 1, 0, 0, 0, 0, 0, nc);
    chk("alu_cycles", 64'(nc), 64'd4);
    chk("alu_cycle_cnt", 64'(cycle_cnt), PERF ? 64'd4 : 64'd0);
    chk("alu_instret", 64'(instret_cnt), PERF ? 64'd1 : 64'd0);

    instr("load_w3", 1, 0, 1, 0, 0, 3, 0, 0, nc);
    chk("load_cycles", 64'(nc), 64'd8);
    chk("load_cycle_cnt", 64'(cycle_cnt), PERF ? 64'd12 : 64'd0);
    chk("load_instret", 64'(instret_cnt), PERF ? 64'd2 : 64'd0);

    instr("store_rwe", 0, 1, 1, 0, 2, 1, 0, 0, nc);
    chk("store_cycles", 64'(nc), 64'd8);

    // Idle with run low: imem_ready alone must not latch IR or start the timeout.
    tag = "idle";
    run = 1'b0; imem_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick(mk(3'd0));
    imem_ready = 1'b0;

    instr("fetch_w7_drop", 0, 0, 0, 0, TO - 1, 0, 1, 0, nc);
    chk("fetch_w7_cycles", 64'(nc), 64'd11);
    instr("load_w7", 1, 0, 1, 0, 0, TO - 1, 0, 0, nc);
    instr("store_w0", 0, 1, 0, 0, 1, 0, 0, 0, nc);
    chk("store_w0_cycles", 64'(nc), 64'd6);

    instr("fetch_timeout", 0, 0, 1, 0, TO, 0, 0, 0, nc);
    chk("fetch_to_bus_err", 64'(bus_err), 64'd1);
    do_reset();
    chk("post_err_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("post_err_bus_err", 64'(bus_err), 64'd0);

    instr("mem_timeout", 0, 1, 0, 0, 0, TO, 0, 0, nc);
    do_reset();

    instr("mem_abort", 0, 1, 1, 0, 0, 2, 0, 1, nc);
    do_reset();

    instr("halt", 1, 1, 1, 1, 0, 0, 0, 0, nc);
    tag = "halt_hold";
    for (int i = 0; i < 100; i++) begin
      run = 1'b1; imem_ready = 1'b1; dmem_ack = 1'b1;
      tick(mk(3'd5));
    end
    imem_ready = 1'b0; dmem_ack = 1'b0;
    chk("halt_cycle_frozen", 64'(cycle_cnt), PERF ? 64'd2 : 64'd0);
    chk("halt_halted", 64'(halted), 64'd1);
    do_reset();

    instr("alu_after_halt", 0, 0, 1, 0, 0, 0, 0, 0, nc);
    chk("final_instret", 64'(instret_cnt), PERF ? 64'd1 : 64'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
